// File: rtl/calc_pkg.sv
// Shared types for the calculator key sequencer: key/command codes,
// calculator status encoding and the sequencer FSM states.
package calc_pkg;

    typedef enum logic [3:0] {
        CMD_D0   = 4'h0, CMD_D1 = 4'h1, CMD_D2 = 4'h2, CMD_D3 = 4'h3,
        CMD_D4   = 4'h4, CMD_D5 = 4'h5, CMD_D6 = 4'h6, CMD_D7 = 4'h7,
        CMD_D8   = 4'h8, CMD_D9 = 4'h9,
        OP_ADD   = 4'hA, OP_SUB = 4'hB, OP_MUL = 4'hC,
        CMD_NOP  = 4'hD, CMD_EQ = 4'hE, CMD_BKSP = 4'hF
    } cmd_t;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ERROR = 2'd2
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_GAP, S_WAIT_DONE, S_CLEAR
    } seq_state_t;

endpackage

// File: rtl/calc_key_fifo.sv
// Small key buffer: power-of-2 depth, wrapping pointers, exact occupancy
// count, synchronous flush that wins over push.
module calc_key_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [3:0]               i_din,
    output logic [3:0]               o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/calc_key_sequencer.sv
// Feeds buffered key codes to calc_top: each key is held on cmd for a fixed
// window, followed by a NOP gap and a wait for the calculator to go idle.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int HOLD_CYCLES  = 10,
    parameter int GAP_CYCLES   = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_key_valid,
    input  logic [3:0]                    i_key_code,
    output logic                          o_key_ready,
    input  logic                          i_clear,
    input  logic [1:0]                    i_calc_status,
    output logic [3:0]                    o_cmd,
    output logic                          o_calc_reset,
    output logic                          o_busy,
    output logic                          o_err,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = $clog2(BUSY_TIMEOUT + 1);

    seq_state_t r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [TW-1:0] r_tcnt, w_tcnt_nxt;
    logic [3:0]    r_cmd, w_cmd_nxt;
    logic          r_err;
    logic          r_calc_reset;
    logic          w_push, w_pop, w_flush, w_err_set;
    logic [3:0]    w_fifo_dout;
    logic          w_full, w_empty;

    assign o_key_ready  = !w_full && !r_err && !i_clear && (r_state != S_CLEAR);
    // NOP keys complete the handshake but never occupy a FIFO slot
    assign w_push       = i_key_valid && o_key_ready && (i_key_code != CMD_NOP);
    assign w_flush      = i_clear || (r_state == S_CLEAR) || w_err_set;
    assign o_cmd        = r_cmd;
    assign o_calc_reset = r_calc_reset;
    assign o_err        = r_err;
    assign o_busy       = (r_state != S_IDLE) || !w_empty;

    calc_key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clock),
        .i_rst   (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_din   (i_key_code),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_fifo_count)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_tcnt       <= '0;
            r_cmd        <= CMD_NOP;
            r_err        <= 1'b0;
            r_calc_reset <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_tcnt       <= w_tcnt_nxt;
            r_cmd        <= w_cmd_nxt;
            r_err        <= i_clear ? 1'b0 : (r_err || w_err_set);
            r_calc_reset <= (w_state_nxt == S_CLEAR);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && (i_calc_status != ST_BUSY)) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD:  if (r_cnt == '0) w_state_nxt = S_GAP;
            S_GAP:   if (r_cnt == '0) w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (i_calc_status == ST_ERROR) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (i_calc_status == ST_BUSY) begin
                    if (r_tcnt == TW'(BUSY_TIMEOUT - 1)) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLEAR: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // clear overrides every other decision made this cycle
        if (i_clear) begin
            w_state_nxt = S_CLEAR;
            w_pop       = 1'b0;
            w_err_set   = 1'b0;
        end
    end

    always_comb begin
        w_cmd_nxt  = CMD_NOP;
        w_cnt_nxt  = r_cnt;
        w_tcnt_nxt = r_tcnt;
        if (w_pop) begin
            w_cmd_nxt = w_fifo_dout;
            w_cnt_nxt = CW'(HOLD_CYCLES - 1);
        end else if (w_state_nxt == S_HOLD) begin
            w_cmd_nxt = r_cmd;
        end
        case (r_state)
            S_HOLD: w_cnt_nxt = (r_cnt == '0) ? CW'(GAP_CYCLES - 1) : r_cnt - CW'(1);
            S_GAP: begin
                if (r_cnt != '0)
                    w_cnt_nxt = r_cnt - CW'(1);
                w_tcnt_nxt = '0;
            end
            S_WAIT_DONE: if (i_calc_status == ST_BUSY) w_tcnt_nxt = r_tcnt + TW'(1);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench: a driver offers keys and pushes the expected cmd windows
// (code, length) into a queue; a monitor extracts windows from cmd and checks.
module tb_calc_key_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       clear;
    logic [1:0] status;
    logic [3:0] cmd;
    logic       calc_reset;
    logic       busy;
    logic       err;
    logic [2:0] fifo_count;

    typedef struct {
        logic [3:0] code;
        int         len;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   saw_full = 1'b0;

    always #5 clk = ~clk;

    calc_key_sequencer dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_key_valid   (key_valid),
        .i_key_code    (key_code),
        .o_key_ready   (key_ready),
        .i_clear       (clear),
        .i_calc_status (status),
        .o_cmd         (cmd),
        .o_calc_reset  (calc_reset),
        .o_busy        (busy),
        .o_err         (err),
        .o_fifo_count  (fifo_count)
    );

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    // Offer one key until accepted; called and returns 1 time unit after a posedge.
    task automatic send_key(input logic [3:0] c, input bit show, input int len);
        bit r = 1'b0;
        key_valid = 1'b1;
        key_code  = c;
        for (int i = 0; i < 400 && !r; i++) begin
            @(negedge clk);
            r = key_ready;
            @(posedge clk);
            #1;
        end
        if (!r) chk("accept_timeout", 0, 1);
        else if (show) q.push_back('{c, len});
        key_valid = 1'b0;
    endtask

    task automatic wait_cmd(input logic [3:0] c, input bit eq);
        bit hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            hit = ((cmd == c) == eq);
        end
        if (!hit) chk("wait_cmd_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit hit = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            @(negedge clk);
            hit = !busy;
        end
        if (!hit) chk("idle_timeout", 0, 1);
    endtask

    // Monitor: every non-NOP run on cmd is one key window.
    initial begin : monitor
        bit         in_win  = 1'b0;
        logic [3:0] w_code  = 4'h0;
        int         w_len   = 0;
        int         nop_run = 100;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (fifo_count == 3'd4) begin
                saw_full = 1'b1;
                chk("ready_when_full", key_ready, 0);
            end
            if (in_win && cmd != w_code) begin
                if (q.size() == 0) chk("unexpected_window", w_code, 4'hD);
                else begin
                    e = q.pop_front();
                    chk("win_code", w_code, e.code);
                    chk("win_len", w_len, e.len);
                end
                in_win = 1'b0;
            end
            if (cmd != 4'hD) begin
                if (!in_win) begin
                    chk("gap_ge4", (nop_run >= 4) ? 1 : 0, 1);
                    in_win = 1'b1;
                    w_code = cmd;
                    w_len  = 1;
                end else w_len++;
                nop_run = 0;
            end else nop_run++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int n;
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; clear = 1'b0; status = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd", cmd, 4'hD);
        chk("rst_calc_reset", calc_reset, 1);
        chk("rst_err", err, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("calc_reset_released", calc_reset, 0);
        @(posedge clk); #1;

        // back-to-back burst, FIFO fills
        send_key(4'h1, 1, 10); send_key(4'h2, 1, 10); send_key(4'h3, 1, 10);
        send_key(4'hA, 1, 10); send_key(4'h1, 1, 10); send_key(4'hE, 1, 10);
        wait_cmd(4'hE, 1);
        wait_cmd(4'hE, 0);
        @(negedge clk);
        @(negedge clk); chk("busy_in_wait_done", busy, 1);
        @(negedge clk); chk("busy_fall", busy, 0);
        chk("reached_full", saw_full, 1);
        @(posedge clk); #1;

        // repeated key registers twice
        send_key(4'h5, 1, 10); send_key(4'h5, 1, 10);
        wait_idle();
        @(posedge clk); #1;

        // BUSY stall after E, a key queued during the stall
        send_key(4'h6, 1, 10); send_key(4'hC, 1, 10);
        send_key(4'h2, 1, 10); send_key(4'hE, 1, 10);
        wait_cmd(4'hE, 1);
        wait_cmd(4'hE, 0);
        @(posedge clk); #1 status = 2'd1;
        send_key(4'h3, 1, 10);
        for (int i = 0; i < 38; i++) begin
            @(negedge clk);
            chk("stall_cmd", cmd, 4'hD);
            chk("stall_busy", busy, 1);
            chk("stall_no_pop", fifo_count, 1);
        end
        @(posedge clk); #1 status = 2'd0;
        wait_idle();
        @(posedge clk); #1;

        // BUSY timeout
        send_key(4'h7, 1, 10); send_key(4'hE, 1, 10);
        wait_cmd(4'hE, 1);
        wait_cmd(4'hE, 0);
        @(posedge clk); #1;
        status = 2'd1; key_valid = 1'b1; key_code = 4'h9;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (n == 2) chk("queued_before_timeout", fifo_count, 1);
            if (err) break;
            @(posedge clk); #1 key_valid = 1'b0;
        end
        key_valid = 1'b0;
        chk("timeout_cycle", n, 257);
        chk("timeout_err", err, 1);
        chk("timeout_flush", fifo_count, 0);
        chk("timeout_ready", key_ready, 0);
        @(posedge clk); #1 status = 2'd0; clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk("clr_state_ready", key_ready, 0);
        chk("clr_state_calc_reset", calc_reset, 1);
        chk("clr_err", err, 0);
        @(negedge clk);
        chk("after_clr_ready", key_ready, 1);
        chk("after_clr_calc_reset", calc_reset, 0);
        @(posedge clk); #1;

        // clear mid-HOLD with 3 keys queued; key offered alongside is dropped
        send_key(4'h8, 1, 3); send_key(4'h1, 0, 0);
        send_key(4'h2, 0, 0); send_key(4'h3, 0, 0);
        clear = 1'b1; key_valid = 1'b1; key_code = 4'h9;
        @(negedge clk);
        chk("pre_clear_count", fifo_count, 3);
        chk("pre_clear_cmd", cmd, 4'h8);
        chk("clear_cycle_ready", key_ready, 0);
        @(posedge clk); #1 clear = 1'b0; key_valid = 1'b0;
        @(negedge clk);
        chk("clear_cmd_nop", cmd, 4'hD);
        chk("clear_calc_reset", calc_reset, 1);
        chk("clear_flush", fifo_count, 0);
        @(negedge clk);
        chk("clear_pulse_len", calc_reset, 0);
        chk("clear_key_dropped", fifo_count, 0);
        @(posedge clk); #1;

        // NOP key is accepted but never buffered
        send_key(4'hD, 0, 0);
        @(negedge clk);
        chk("nop_not_enqueued", fifo_count, 0);
        @(posedge clk); #1;
        send_key(4'h4, 1, 10);
        wait_idle();
        @(posedge clk); #1;

        // reset mid-operation
        send_key(4'h2, 1, 2); send_key(4'h6, 0, 0); send_key(4'h7, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_cmd", cmd, 4'hD);
        chk("midrst_calc_reset", calc_reset, 1);
        chk("midrst_fifo", fifo_count, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_stays_idle", busy, 0);
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/calc_key_sequencer.md
Name: calc_key_sequencer

Overview:
- Sits between a key source (keypad scanner or scripted driver) and calc_top.
- Buffers key codes in a small FIFO and presents each one on calc_top's cmd input for a fixed hold window.
- Inserts a NOP gap between keys so that a repeated key registers twice.
- Stalls while the calculator reports BUSY, and owns calc_top's reset via a clear request.

Parameters:
- HOLD_CYCLES, 10: cycles each key is driven on cmd (min 1).
- GAP_CYCLES, 2: NOP cycles after each key (min 1).
- FIFO_DEPTH, 4: key buffer entries (power of 2, min 2).
- BUSY_TIMEOUT, 255: maximum cycles spent waiting for BUSY to drop.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- key_valid  in  1  key offered
- key_code  in  4  offered key
- key_ready  out  1  key accepted when key_valid && key_ready
- clear  in  1  one-cycle request: flush and reset calculator
- calc_status  in  2  calculator status: 0 READY, 1 BUSY, 2 ERROR, 3 treated as READY
- cmd  out  4  command to calc_top
- calc_reset  out  1  reset to calc_top
- busy  out  1  state != IDLE, or FIFO non-empty
- err  out  1  sticky: calculator ERROR or timeout
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Key codes:
  - 0-9 digits.
  - A add, B sub, C mul, E equals, F backspace.
  - D is NOP. D is never enqueued: it is accepted, then dropped.
- Reset values: cmd=NOP (4'hD), calc_reset=1, err=0, fifo_count=0, state=IDLE.
  - calc_reset deasserts on the first cycle after reset is released.
- Handshake: key_ready = !full && !err && !clear && state!=CLEAR.
  - No full-FIFO bypass: a pop in the same cycle does not raise key_ready.
- FSM states: IDLE, HOLD, GAP, WAIT_DONE, CLEAR. cmd is registered.
  - IDLE: cmd=NOP. If the FIFO is non-empty and calc_status!=BUSY: pop, load cmd with the key, cnt=HOLD_CYCLES-1, go to HOLD.
  - HOLD: cmd holds the key. When cnt==0: cmd=NOP, cnt=GAP_CYCLES-1, go to GAP.
  - GAP: cmd=NOP. When cnt==0: tcnt=0, go to WAIT_DONE.
  - WAIT_DONE: cmd=NOP, minimum 1 cycle.
    - READY (or 3): go to IDLE.
    - ERROR: set err, flush FIFO, go to IDLE.
    - BUSY: increment tcnt. When tcnt reaches BUSY_TIMEOUT: set err, flush FIFO, go to IDLE.
  - CLEAR: exactly 1 cycle. calc_reset=1, cmd=NOP, FIFO flushed, err=0, then go to IDLE.
- clear in any state: next state is CLEAR. clear has priority over push, pop and err updates. A key offered in the same cycle is not accepted.
- Latency, empty FIFO, status READY:
  - key accepted at cycle t; pop at t+1; cmd=key during t+2..t+1+HOLD_CYCLES.
  - NOP for GAP_CYCLES, then at least 1 WAIT_DONE cycle.
  - Minimum key-to-key spacing on cmd = HOLD_CYCLES+GAP_CYCLES+2.
- While err=1: the FIFO stays empty and key_ready=0. Only clear or reset recovers.
- Reset mid-operation: all state is discarded and outputs return to their reset values.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count is exact under simultaneous push/pop.

Decomposition:
- Package calc_pkg holds:
  - typedef enum cmd_t: digits, OP_ADD=A, OP_SUB=B, OP_MUL=C, CMD_NOP=D, CMD_EQ=E, CMD_BKSP=F.
  - typedef enum status_t: READY, BUSY, ERROR.
  - typedef enum seq_state_t for the FSM.
- Sub-module calc_key_fifo holds the FIFO:
  - Parameter: DEPTH.
  - Ports: push, pop, flush, din, dout, full, empty, count.
  - Synchronous flush.

Test Plan:
- Reset, then push 1,2,3,A,1,E back-to-back with status READY:
  - cmd shows 1,2,3,A,1,E, each held 10 cycles, separated by 2+ NOP cycles.
  - key_ready drops while fifo_count=4.
  - busy falls 1 cycle after the final WAIT_DONE.
- Push 5,5:
  - two separate 10-cycle windows of cmd=5 with cmd=NOP between them.
- Push 6,C,2,E; hold status=BUSY for 40 cycles after E's gap:
  - cmd stays NOP and busy=1 during the stall.
  - The next queued key is not popped until status=READY.
- Push 7,E; hold status=BUSY for more than 255 cycles:
  - err=1 at the timeout cycle, fifo_count=0, key_ready=0.
  - clear restores err=0 and key_ready=1 after the CLEAR cycle.
- Assert clear mid-HOLD with 3 keys queued:
  - next cycle: cmd=NOP and calc_reset=1 for exactly 1 cycle, fifo_count=0.
  - A key offered in the clear cycle is not accepted.
- Push D, then 4:
  - D accepted, fifo_count stays 0, D never appears on cmd.
  - 4 is driven normally.
